dict_seq: RTL and testbench

DICT_SEQ -- requirements
Module: dict_seq

---
 rtl/dict_seq.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_dict_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dict_seq.sv
// dict_seq: key/value dictionary with sequential key search and direct slot access.
// Define DICT_SEQ_HIT_CACHE_EN to add a last-hit slot check ahead of the scan.
module dict_seq #(
   parameter int unsigned ENTRIES      = 16,
   parameter int unsigned KEY_WIDTH    = 8,
   parameter int unsigned KEY_LENGTH   = 4,
   parameter int unsigned VALUE_WIDTH  = 32,
   parameter int unsigned VALUE_LENGTH = 1,
   localparam int unsigned KW = KEY_WIDTH * KEY_LENGTH,
   localparam int unsigned VW = VALUE_WIDTH * VALUE_LENGTH,
   localparam int unsigned IB = $clog2(ENTRIES),
   localparam int unsigned CB = $clog2(ENTRIES + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [2:0]    i_op,
   input  logic [KW-1:0] i_key,
   input  logic [VW-1:0] i_value,
   input  logic [IB-1:0] i_index,
   output logic [VW-1:0] o_value,
   output logic [IB-1:0] o_index,
   output logic          o_done,
   output logic          o_err,
   output logic [CB-1:0] o_count,
   output logic          o_full,
   output logic [2:0]    d_state
);

   localparam logic [2:0] OP_SET         = 3'd0;
   localparam logic [2:0] OP_GET         = 3'd1;
   localparam logic [2:0] OP_ENCODE      = 3'd2;
   localparam logic [2:0] OP_SET_FAST    = 3'd3;
   localparam logic [2:0] OP_GET_FAST    = 3'd4;
   localparam logic [2:0] OP_DELETE      = 3'd5;
   localparam logic [2:0] OP_DELETE_FAST = 3'd6;
   localparam logic [2:0] OP_CLEAR       = 3'd7;

   localparam logic [IB-1:0] LP_LAST    = IB'(ENTRIES - 1);
   localparam logic [IB-1:0] LP_IDX_ONE = IB'(1);
   localparam logic [IB:0]   LP_ENT_IB  = (IB + 1)'(ENTRIES);
   localparam logic [CB-1:0] LP_FULL    = CB'(ENTRIES);
   localparam logic [CB-1:0] LP_CNT_ONE = CB'(1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StScan  = 2'd1,
`ifdef DICT_SEQ_HIT_CACHE_EN
      StCache = 2'd3,
`endif
      StDone  = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_ready;
   logic                r_done;
   logic                r_err;
   logic [VW-1:0]       r_value;
   logic [IB-1:0]       r_oidx;
   logic [CB-1:0]       r_count;
   logic [ENTRIES-1:0]  r_valid;
   logic [2:0]          r_op;
   logic [KW-1:0]       r_key;
   logic [VW-1:0]       r_wval;
   logic [IB-1:0]       r_index;
   logic [IB-1:0]       r_scan;
   logic                r_free_found;
   logic [IB-1:0]       r_free_idx;
   logic [KW-1:0]       r_key_mem [ENTRIES];
   logic [VW-1:0]       r_val_mem [ENTRIES];
`ifdef DICT_SEQ_HIT_CACHE_EN
   logic [IB-1:0]       r_cache_idx;
   logic                r_cache_vld;
`endif

   logic [IB-1:0] w_cur;
   logic          w_hit;
   logic          w_last;
   logic          w_finish;
   logic          w_free_any;
   logic [IB-1:0] w_free_idx;
   logic          w_idx_ok;
   logic          w_fast_vld;
   logic          w_is_search;
   logic          w_we;
   logic [IB-1:0] w_widx;

   // Slot under comparison: the cached slot in CACHE, the scan pointer otherwise.
   always_comb begin
      w_cur    = r_scan;
      w_finish = 1'b0;
`ifdef DICT_SEQ_HIT_CACHE_EN
      if (r_state == StCache) begin
         w_cur = r_cache_idx;
      end
`endif
      w_hit = r_valid[w_cur] && (r_key_mem[w_cur] == r_key);
`ifdef DICT_SEQ_HIT_CACHE_EN
      if (r_state == StCache) begin
         w_hit    = w_hit && r_cache_vld;
         w_finish = w_hit;
      end
`endif
      w_last = (r_scan == LP_LAST);
      if (r_state == StScan) begin
         w_finish = w_hit || w_last;
      end
   end

   assign w_free_any  = r_free_found || !r_valid[w_cur];
   assign w_free_idx  = r_free_found ? r_free_idx : w_cur;
   assign w_idx_ok    = ({1'b0, r_index} < LP_ENT_IB);
   assign w_fast_vld  = w_idx_ok && r_valid[r_index];
   assign w_is_search = (i_op == OP_SET) || (i_op == OP_GET) || (i_op == OP_ENCODE) ||
                        (i_op == OP_DELETE);

   always_comb begin
      w_we   = 1'b0;
      w_widx = r_index;
      if (w_finish && (r_op == OP_SET) && (w_hit || w_free_any)) begin
         w_we   = 1'b1;
         w_widx = w_hit ? w_cur : w_free_idx;
      end else if ((r_state == StDone) && (r_op == OP_SET_FAST) && w_idx_ok) begin
         w_we = 1'b1;
      end
   end

   // Key/value storage carries no reset; the valid bits alone define occupancy.
   always_ff @(posedge i_clk) begin
      if (i_en && w_we) begin
         r_key_mem[w_widx] <= r_key;
         r_val_mem[w_widx] <= r_wval;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_ready      <= 1'b1;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_value      <= '0;
         r_oidx       <= '0;
         r_count      <= '0;
         r_valid      <= '0;
         r_op         <= OP_SET;
         r_key        <= '0;
         r_wval       <= '0;
         r_index      <= '0;
         r_scan       <= '0;
         r_free_found <= 1'b0;
         r_free_idx   <= '0;
`ifdef DICT_SEQ_HIT_CACHE_EN
         r_cache_idx  <= '0;
         r_cache_vld  <= 1'b0;
`endif
      end else if (i_en) begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_valid) begin
                  r_op         <= i_op;
                  r_key        <= i_key;
                  r_wval       <= i_value;
                  r_index      <= i_index;
                  r_ready      <= 1'b0;
                  r_scan       <= '0;
                  r_free_found <= 1'b0;
                  if (w_is_search) begin
`ifdef DICT_SEQ_HIT_CACHE_EN
                     r_state <= StCache;
`else
                     r_state <= StScan;
`endif
                  end else begin
                     r_state <= StDone;
                  end
               end
            end
`ifdef DICT_SEQ_HIT_CACHE_EN
            StCache: r_state <= StScan;
`endif
            StScan: begin
               r_scan <= r_scan + LP_IDX_ONE;
               if (!r_free_found && !r_valid[r_scan]) begin
                  r_free_found <= 1'b1;
                  r_free_idx   <= r_scan;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_ready <= 1'b1;
            end
            default: r_state <= StIdle;
         endcase

         // Search completion overrides the plain state advance above.
         if (w_finish) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_value <= '0;
            r_oidx  <= w_cur;
            if (w_hit) begin
               if ((r_op == OP_GET) || (r_op == OP_DELETE)) begin
                  r_value <= r_val_mem[w_cur];
               end
               if (r_op == OP_DELETE) begin
                  r_valid[w_cur] <= 1'b0;
                  r_count        <= r_count - LP_CNT_ONE;
               end
`ifdef DICT_SEQ_HIT_CACHE_EN
               if (r_op == OP_DELETE) begin
                  if (r_cache_idx == w_cur) begin
                     r_cache_vld <= 1'b0;
                  end
               end else begin
                  r_cache_idx <= w_cur;
                  r_cache_vld <= 1'b1;
               end
`endif
            end else if ((r_op == OP_SET) && w_free_any) begin
               r_oidx              <= w_free_idx;
               r_valid[w_free_idx] <= 1'b1;
               r_count             <= r_count + LP_CNT_ONE;
`ifdef DICT_SEQ_HIT_CACHE_EN
               r_cache_idx         <= w_free_idx;
               r_cache_vld         <= 1'b1;
`endif
            end else begin
               r_err  <= 1'b1;
               r_oidx <= '0;
            end
         end

         if ((r_state == StDone) && !(r_op == OP_SET || r_op == OP_GET ||
                                      r_op == OP_ENCODE || r_op == OP_DELETE)) begin
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_value <= '0;
            r_oidx  <= r_index;
            case (r_op)
               OP_SET_FAST: begin
                  if (w_idx_ok) begin
                     r_valid[r_index] <= 1'b1;
                     if (!r_valid[r_index]) begin
                        r_count <= r_count + LP_CNT_ONE;
                     end
`ifdef DICT_SEQ_HIT_CACHE_EN
                     r_cache_idx <= r_index;
                     r_cache_vld <= 1'b1;
`endif
                  end else begin
                     r_err  <= 1'b1;
                     r_oidx <= '0;
                  end
               end
               OP_GET_FAST, OP_DELETE_FAST: begin
                  if (w_fast_vld) begin
                     r_value <= r_val_mem[r_index];
                     if (r_op == OP_DELETE_FAST) begin
                        r_valid[r_index] <= 1'b0;
                        r_count          <= r_count - LP_CNT_ONE;
`ifdef DICT_SEQ_HIT_CACHE_EN
                        if (r_cache_idx == r_index) begin
                           r_cache_vld <= 1'b0;
                        end
`endif
                     end
                  end else begin
                     r_err  <= 1'b1;
                     r_oidx <= '0;
                  end
               end
               default: begin
                  r_valid <= '0;
                  r_count <= '0;
                  r_oidx  <= '0;
`ifdef DICT_SEQ_HIT_CACHE_EN
                  r_cache_vld <= 1'b0;
`endif
               end
            endcase
         end
      end
   end

   assign o_ready = r_ready;
   assign o_done  = r_done;
   assign o_err   = r_err;
   assign o_value = r_value;
   assign o_index = r_oidx;
   assign o_count = r_count;
   assign o_full  = (r_count == LP_FULL);
   assign d_state = {1'b0, r_state};

endmodule

// File: tb/tb_dict_seq.sv
// Scoreboard bench for dict_seq (ENTRIES=5, 8-bit keys, 32-bit values).
// Honours DICT_SEQ_HIT_CACHE_EN in its reference model when the DUT is built with it.
module tb_dict_seq;
   localparam int E = 5;

   localparam logic [2:0] OP_SET  = 3'd0, OP_GET  = 3'd1, OP_ENC  = 3'd2, OP_SETF = 3'd3;
   localparam logic [2:0] OP_GETF = 3'd4, OP_DEL  = 3'd5, OP_DELF = 3'd6, OP_CLR  = 3'd7;

`ifdef DICT_SEQ_HIT_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_en = 1'b1;
   logic        i_valid = 1'b0;
   logic [2:0]  i_op = 3'd0;
   logic [7:0]  i_key = 8'd0;
   logic [31:0] i_value = 32'd0;
   logic [2:0]  i_index = 3'd0;
   logic        o_ready, o_done, o_err, o_full;
   logic [31:0] o_value;
   logic [2:0]  o_index, o_count, d_state;

   dict_seq #(
      .ENTRIES(E), .KEY_WIDTH(8), .KEY_LENGTH(1), .VALUE_WIDTH(32), .VALUE_LENGTH(1)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_key(i_key), .i_value(i_value), .i_index(i_index),
      .o_value(o_value), .o_index(o_index), .o_done(o_done), .o_err(o_err),
      .o_count(o_count), .o_full(o_full), .d_state(d_state)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      bit          err;
      logic [31:0] val;
      logic [2:0]  idx;
      int          cnt;
      bit          cv;
      bit          ci;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference dictionary state.
   logic [7:0]  m_key [E];
   logic [31:0] m_val [E];
   bit          m_vld [E];
   int          m_ci;
   bit          m_cv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int mcount();
      int c = 0;
      for (int j = 0; j < E; j++) if (m_vld[j]) c++;
      return c;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < E; j++) m_vld[j] = 1'b0;
      m_cv = 1'b0;
      m_ci = 0;
   endtask

   task automatic model(input logic [2:0] op, input logic [7:0] key, input logic [31:0] val,
                        input logic [2:0] idx, input int k);
      exp_t e;
      int   s, f, lat;
      e.err = 1'b0; e.val = '0; e.idx = '0; e.cv = 1'b0; e.ci = 1'b0;
      lat = 2;
      if (op == OP_SET || op == OP_GET || op == OP_ENC || op == OP_DEL) begin
         s = -1;
         if (CACHE && m_cv && m_vld[m_ci] && m_key[m_ci] == key) begin
            s = m_ci;
         end else begin
            for (int j = 0; j < E; j++)
               if (s < 0 && m_vld[j] && m_key[j] == key) s = j;
            lat = (s >= 0) ? (CACHE ? 3 : 2) + s : (CACHE ? 2 : 1) + E;
         end
         e.ci = 1'b1;
         e.cv = (op == OP_GET || op == OP_DEL);
         if (s >= 0) begin
            e.idx = 3'(s);
            if (op == OP_SET) m_val[s] = val;
            if (op == OP_GET || op == OP_DEL) e.val = m_val[s];
            if (op == OP_DEL) begin
               m_vld[s] = 1'b0;
               if (m_ci == s) m_cv = 1'b0;
            end else begin
               m_ci = s;
               m_cv = 1'b1;
            end
         end else if (op == OP_SET) begin
            f = -1;
            for (int j = E - 1; j >= 0; j--) if (!m_vld[j]) f = j;
            if (f >= 0) begin
               m_key[f] = key; m_val[f] = val; m_vld[f] = 1'b1;
               e.idx = 3'(f);
               m_ci = f; m_cv = 1'b1;
            end else begin
               e.err = 1'b1;
               e.ci  = 1'b0;
            end
         end else begin
            e.err = 1'b1;
         end
      end else if (op == OP_SETF) begin
         if (int'(idx) < E) begin
            m_key[idx] = key; m_val[idx] = val; m_vld[idx] = 1'b1;
            e.idx = idx; e.ci = 1'b1;
            m_ci = int'(idx); m_cv = 1'b1;
         end else begin
            e.err = 1'b1;
         end
      end else if (op == OP_GETF || op == OP_DELF) begin
         e.cv = 1'b1;
         if (int'(idx) < E && m_vld[idx]) begin
            e.val = m_val[idx]; e.idx = idx; e.ci = 1'b1;
            if (op == OP_DELF) begin
               m_vld[idx] = 1'b0;
               if (m_ci == int'(idx)) m_cv = 1'b0;
            end
         end else begin
            e.err = 1'b1;
         end
      end else begin
         for (int j = 0; j < E; j++) m_vld[j] = 1'b0;
         m_cv = 1'b0;
      end
      e.cnt = mcount();
      e.cyc = k + lat;
      q.push_back(e);
   endtask

   // Busy cycles carry junk requests that the DUT must ignore.
   task automatic issue(input logic [2:0] op, input logic [7:0] key, input logic [31:0] val,
                        input logic [2:0] idx);
      int guard = 0;
      @(negedge i_clk);
      while (!o_ready) begin
         i_valid = 1'($urandom_range(0, 1));
         i_op    = 3'($urandom_range(0, 7));
         i_key   = 8'($urandom_range(0, 7));
         i_value = $urandom;
         i_index = 3'($urandom_range(0, 7));
         guard++;
         if (guard > 100) begin
            $display("FAIL ready_timeout: o_ready=0 required 1 after %0d cycles", guard);
            $fatal(1, "o_ready stuck low");
         end
         @(negedge i_clk);
      end
      i_valid = 1'b1; i_op = op; i_key = key; i_value = val; i_index = idx;
      model(op, key, val, idx, cyc);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_key   = 8'($urandom);
      i_value = $urandom;
      i_index = 3'($urandom);
   endtask

   task automatic wait_idle();
      int g = 0;
      while (q.size() != 0 || !o_ready) begin
         @(negedge i_clk);
         g++;
         if (g > 100) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d completions outstanding, required 0", q.size());
            q.delete();
            break;
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (!i_rst && o_done) begin
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_done: o_done=1 required 0 (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               chk("done_cycle", 64'(cyc), 64'(e.cyc));
               chk("err", 64'(o_err), 64'(e.err));
               if (e.cv) chk("value", 64'(o_value), 64'(e.val));
               if (e.ci) chk("index", 64'(o_index), 64'(e.idx));
               chk("count", 64'(o_count), 64'(e.cnt));
               chk("full", 64'(o_full), 64'(e.cnt == E));
            end
         end
      end
   end

   initial begin
      logic [2:0] op;
      model_reset();
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_state", 64'(d_state), 64'(0));
      chk("rst_ready", 64'(o_ready), 64'(1));
      chk("rst_done", 64'(o_done), 64'(0));
      chk("rst_count", 64'(o_count), 64'(0));
      chk("rst_value", 64'(o_value), 64'(0));

      issue(OP_GET, 8'h41, 32'h0, 3'd0);
      issue(OP_SET, 8'h41, 32'hDEADBEEF, 3'd0);
      issue(OP_GET, 8'h41, 32'h0, 3'd0);
      issue(OP_CLR, 8'h00, 32'h0, 3'd0);
      for (int k = 0; k < E; k++) issue(OP_SET, 8'(k), $urandom, 3'd0);
      issue(OP_SET, 8'h05, 32'h55, 3'd0);
      issue(OP_SET, 8'h02, 32'h7, 3'd0);
      issue(OP_DEL, 8'h01, 32'h0, 3'd0);
      issue(OP_SET, 8'h09, 32'h99, 3'd0);
      issue(OP_GETF, 8'h00, 32'h0, 3'd6);
      issue(OP_CLR, 8'h00, 32'h0, 3'd0);

      // Leave the last-hit slot at 2 so the first lookup of key 4 must scan.
      for (int k = 0; k < E; k++) issue(OP_SET, 8'(k), 32'h100 + 32'(k), 3'd0);
      issue(OP_SET, 8'h02, 32'h222, 3'd0);
      issue(OP_GET, 8'h04, 32'h0, 3'd0);
      issue(OP_GET, 8'h04, 32'h0, 3'd0);
      issue(OP_DEL, 8'h04, 32'h0, 3'd0);
      issue(OP_GET, 8'h04, 32'h0, 3'd0);
      issue(OP_SETF, 8'h44, 32'h4444, 3'd4);
      issue(OP_DELF, 8'h00, 32'h0, 3'd4);
      issue(OP_DELF, 8'h00, 32'h0, 3'd4);
      issue(OP_ENC, 8'h03, 32'h0, 3'd0);
      issue(OP_CLR, 8'h00, 32'h0, 3'd0);

      // Abort a scan with reset three cycles after acceptance.
      issue(OP_SET, 8'h77, 32'hCAFEF00D, 3'd0);
      issue(OP_GET, 8'h77, 32'h0, 3'd0);
      wait_idle();
      issue(OP_GET, 8'h33, 32'h0, 3'd0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      q.delete();
      model_reset();
      #1;
      chk("abort_done", 64'(o_done), 64'(0));
      chk("abort_state", 64'(d_state), 64'(0));
      chk("abort_ready", 64'(o_ready), 64'(1));
      chk("abort_value", 64'(o_value), 64'(0));
      chk("abort_index", 64'(o_index), 64'(0));
      chk("abort_err", 64'(o_err), 64'(0));
      chk("abort_count", 64'(o_count), 64'(0));
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (10) @(negedge i_clk);
      issue(OP_GET, 8'h77, 32'h0, 3'd0);

      for (int n = 0; n < 300; n++) begin
         op = 3'($urandom_range(0, 7));
         if (op == OP_CLR && $urandom_range(0, 3) != 0) op = OP_GET;
         issue(op, 8'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)));
      end
      wait_idle();
      repeat (4) @(negedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
